// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture checker: segment codes,
// FSM state encoding and output bit positions.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    LOCKED     = 1'b1
  } state_t;

  localparam int unsigned OUT_VALID   = 4;
  localparam int unsigned OUT_PAT_ERR = 5;
  localparam int unsigned OUT_SEQ_ERR = 6;
  localparam int unsigned OUT_STROBE  = 7;

endpackage

// File: rtl/seg7_reader_if.sv
// Dedicated TT-style I/O bundle of the seven-segment reader.
interface seg7_reader_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (output ena, output ui_in, input uo_out);
  modport slave  (input ena, input ui_in, output uo_out);
endinterface

// File: rtl/seg7_decode.sv
// Combinational inverse of the seven-segment display encoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_blank
);

  always_comb begin
    digit    = '0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment loopback checker: synchronise, debounce, decode and verify
// that captured digits follow the 0..9 counting sequence.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_reader_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_ARM  = 8'(STABLE_CYCLES - 2);

  logic [7:0] sync1, sync2;
  logic [6:0] s, cand, acc_pat;
  logic       clr_req;
  logic [7:0] cnt;
  logic       acc;

  state_t     state, state_n;
  logic [3:0] digit, digit_n, succ;
  logic       valid, valid_n, pat_err, pat_err_n, seq_err, seq_err_n;
  logic       strobe, strobe_n;

  logic [3:0] dec_digit;
  logic       dec_is_digit, dec_is_blank;

  assign s       = sync2[6:0];
  assign clr_req = sync2[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.ui_in;
      sync2 <= sync1;
    end
  end

  // A candidate equal to the last accepted pattern (e.g. after a short glitch
  // away and back) is not re-accepted, so a held digit never double-counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= '0;
      cnt     <= '0;
      acc     <= 1'b0;
      acc_pat <= SEG_BLANK;
    end else if (bus.ena) begin
      acc <= (s == cand) && (cnt == CNT_ARM) && (cand != acc_pat);
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 8'd1;
        if (cnt == CNT_ARM) acc_pat <= cand;
      end
    end
  end

  seg7_decode u_decode (
    .pattern  (cand),
    .digit    (dec_digit),
    .is_digit (dec_is_digit),
    .is_blank (dec_is_blank)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_FIRST;
      digit   <= '0;
      valid   <= 1'b0;
      pat_err <= 1'b0;
      seq_err <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      state   <= state_n;
      digit   <= digit_n;
      valid   <= valid_n;
      pat_err <= pat_err_n;
      seq_err <= seq_err_n;
      strobe  <= strobe_n;
    end
  end

  assign succ = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  always_comb begin
    state_n   = state;
    digit_n   = digit;
    valid_n   = valid;
    pat_err_n = pat_err;
    seq_err_n = seq_err;
    strobe_n  = 1'b0;
    if (bus.ena) begin
      if (clr_req) begin
        pat_err_n = 1'b0;
        seq_err_n = 1'b0;
      end
      if (acc) begin
        if (dec_is_digit) begin
          digit_n  = dec_digit;
          valid_n  = 1'b1;
          strobe_n = 1'b1;
          case (state)
            WAIT_FIRST: state_n = LOCKED;
            LOCKED:     if (dec_digit != succ) seq_err_n = 1'b1;
            default:    state_n = WAIT_FIRST;
          endcase
        end else if (!dec_is_blank) begin
          pat_err_n = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.uo_out              = '0;
    bus.uo_out[3:0]         = digit;
    bus.uo_out[OUT_VALID]   = valid;
    bus.uo_out[OUT_PAT_ERR] = pat_err;
    bus.uo_out[OUT_SEQ_ERR] = seq_err;
    bus.uo_out[OUT_STROBE]  = strobe;
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader with STABLE_CYCLES = 4.
module tb_seg7_reader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seg7_reader_if bus ();

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [7:0] v, input int n, output int strobes);
    strobes = 0;
    bus.ui_in = v;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.uo_out[7] === 1'b1) strobes++;
    end
  endtask

  logic [6:0] pats [9];
  logic [3:0] digs [9];
  int st, st2;

  initial begin
    pats = '{7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};
    digs = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    bus.ena   = 1'b1;
    bus.ui_in = 8'h3F;

    // reset held with a legal pattern present
    repeat (3) step();
    chk("reset_out", bus.uo_out, 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("first_wait_%0d", i), bus.uo_out, 8'h00);
    end
    step();
    chk("first_strobe", bus.uo_out, 8'h90);
    step();
    chk("first_settled", bus.uo_out, 8'h10);
    repeat (2) step();

    // short glitch to 1 and back to 0 is rejected
    hold(8'h06, 3, st);
    hold(8'h3F, 8, st2);
    chk("glitch_strobes", st + st2, 0);
    chk("glitch_out", bus.uo_out, 8'h10);
    hold(8'h06, 8, st);
    chk("digit1_strobes", st, 1);
    chk("digit1_out", bus.uo_out, 8'h11);

    // counting sequence 2..9 then wrap to 0
    for (int i = 0; i < 9; i++) begin
      hold({1'b0, pats[i]}, 8, st);
      chk($sformatf("seq_strobes_%0d", digs[i]), st, 1);
      chk($sformatf("seq_out_%0d", digs[i]), bus.uo_out, {4'h1, digs[i]});
    end

    // out-of-order digit 4 after 0
    hold(8'h66, 8, st);
    chk("seqerr_strobes", st, 1);
    chk("seqerr_out", bus.uo_out, 8'h54);

    // illegal pattern then blank
    hold(8'h49, 8, st);
    chk("illegal_strobes", st, 0);
    chk("illegal_out", bus.uo_out, 8'h74);
    hold(8'h00, 8, st);
    chk("blank_strobes", st, 0);
    chk("blank_out", bus.uo_out, 8'h74);

    // error clear with 3-edge latency
    bus.ui_in = 8'h80;
    repeat (2) step();
    chk("clear_pending", bus.uo_out, 8'h74);
    step();
    chk("clear_done", bus.uo_out, 8'h14);
    repeat (2) step();

    // clear held while a new illegal pattern is accepted
    bus.ui_in = 8'hC9;
    repeat (6) step();
    chk("collide_before", bus.uo_out, 8'h14);
    step();
    chk("collide_error_wins", bus.uo_out, 8'h34);
    step();
    chk("collide_cleared", bus.uo_out, 8'h14);

    // enable low freezes everything
    bus.ena = 1'b0;
    hold(8'h6D, 20, st);
    chk("ena_low_strobes", st, 0);
    chk("ena_low_out", bus.uo_out, 8'h14);
    bus.ena = 1'b1;
    repeat (4) step();
    chk("ena_high_wait", bus.uo_out, 8'h14);
    step();
    chk("ena_high_update", bus.uo_out, 8'h95);
    step();
    chk("ena_high_settled", bus.uo_out, 8'h15);

    // asynchronous reset mid-window, then restart from WAIT_FIRST
    bus.ui_in = 8'h7D;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("async_reset", bus.uo_out, 8'h00);
    repeat (2) step();
    chk("reset_held", bus.uo_out, 8'h00);
    rst_n = 1'b1;
    hold(8'h7D, 8, st);
    chk("restart_strobes", st, 1);
    chk("restart_out", bus.uo_out, 8'h16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Capture-side companion to the seven-segment counter demo: takes a seven-segment pattern on the dedicated inputs (e.g. wired from another board's display outputs), synchronises and debounces it, and decodes it back to a BCD digit. It also checks that successive digits follow the 0→9→0 counting sequence, and flags illegal patterns and sequence breaks as sticky errors on the dedicated outputs. It is a self-contained TT user module used as a loopback checker for the counter/display path.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical synchronised samples required to accept a pattern; legal range 2..255.
- `clk`  in  1  system clock (10 MHz on board).
- `rst_n`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `ena`  in  1  design enable; low freezes debounce, decode and error state.
- `ui_in`  in  8  [6:0] segment pattern, active-high, bit0 = a … bit6 = g; [7] error-clear request, level.
- `uo_out`  out  8  [3:0] last accepted digit; [4] valid; [5] pattern error, sticky; [6] sequence error, sticky; [7] update strobe.

## Operation
- All of `ui_in[7:0]` passes through a 2-flop synchroniser. The synchroniser runs even when `ena` = 0.
- Debounce:
  - The synchronised pattern `s` is compared with the candidate register `cand`.
  - If `s` ≠ `cand`: load `cand` ← `s` and clear the stability counter.
  - Otherwise the counter increments, saturating at `STABLE_CYCLES`−1.
  - Acceptance happens on the edge where the counter reaches `STABLE_CYCLES`−1. Acceptance fires once per candidate and never re-fires while the pattern is held.
- Decode of the accepted pattern:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x00 is blank: no output change, no error, no strobe.
  - Any other pattern is illegal: set pattern error; digit and valid are unchanged.
- FSM with two states:
  - `WAIT_FIRST` (reset state): a legal digit loads the digit, sets valid, pulses the strobe and moves to `LOCKED`. No sequence check in this state.
  - `LOCKED`: a legal digit loads the digit and pulses the strobe. If the new digit ≠ (previous + 1) mod 10, set sequence error. 9→0 is legal wrap-around.
  - Re-acceptance of a digit equal to the current one cannot occur, because acceptance requires a change of `cand`. A return to the same digit via blank or illegal patterns in between is checked normally; e.g. 3, blank, 3 sets sequence error.
  - Only `rst_n` returns the FSM to `WAIT_FIRST`.
- Error clear:
  - A synchronised `ui_in[7]` = 1 clears both sticky errors on every enabled cycle.
  - If a new error is detected on the same edge as a clear, the error wins (bit ends at 1).
- Strobe `uo_out[7]` is high for exactly one cycle per digit update.
- `ena` = 0: counter, `cand`, FSM, digit and errors hold, strobe is 0, and clear is ignored.
- Arithmetic: stability counter is 8 bits; the mod-10 successor is computed as digit == 9 ? 0 : digit + 1 on 4 bits.

## Timing
- All outputs are registered. Reset value of `uo_out` is 0x00 (digit 0, valid 0, errors 0, strobe 0). `cand` resets to 0x00 and the counter to 0.
- A pattern change on `ui_in` first sampled at edge N produces its output update at edge N + 2 + `STABLE_CYCLES`. This assumes the pattern is held and `ena` = 1 throughout.
- Any change of `s` before acceptance restarts the full `STABLE_CYCLES` window. There is no partial credit.
- Error-clear latency: 3 edges from the `ui_in[7]` rise to the bits reading 0.
- `rst_n` asserted mid-debounce or mid-strobe: outputs go to 0x00 asynchronously, with no glitch strobe on release. After release, operation restarts from `WAIT_FIRST`.

## Structure
- Package `seg7_pkg` holds:
  - the ten digit pattern localparams and `SEG_BLANK`;
  - the FSM state enum (`WAIT_FIRST`, `LOCKED`);
  - the `uo_out` bit-index constants.
- Sub-module `seg7_decode`, combinational, inverse of the display encoder: input pattern[6:0]; outputs digit[3:0], is_digit, is_blank. The top contains the synchroniser, debounce, FSM and error logic.

## Test plan
All scenarios use `STABLE_CYCLES` = 4.
- Reset: hold `rst_n` = 0 with `ui_in` = 0x3F → `uo_out` = 0x00. After release, 0x3F held 10 cycles → `uo_out` = 0x90 (strobe, valid, digit 0) for one cycle exactly 6 edges after the first sampling edge, then 0x10.
- Glitch rejection: from digit 0, drive 0x06 for 3 cycles, then 0x3F → no strobe, `uo_out` stays 0x10. Then 0x06 held → digit 1, no errors.
- Full sequence: patterns for 1..9, then 0x3F, each held 8 cycles → ten strobes, digits 1..9,0, `uo_out[6:5]` = 00. Then 0x66 → digit 4, sequence error set (`uo_out` = 0x54 after the strobe).
- Illegal and blank: 0x49 held → pattern error set, digit unchanged, no strobe. 0x00 held → no change. Then `ui_in[7]` = 1 for 5 cycles → both errors clear.
- Clear-vs-error collision: hold `ui_in` = 0xC9 (clear high plus illegal 0x49) → pattern error reads 1 after acceptance, then 0 on the next enabled edge.
- `ena` low: drive the next digit with `ena` = 0 for 20 cycles → no change. Raise `ena` → update after 4 more edges. Assert `rst_n` mid-window → 0x00 immediately.
